// File: rtl/bcrypt_core_din.sv
`default_nettype none
// bcrypt_core_din -- assembles bytes from the bcrypt distribution bus into 32-bit
// words for the init memory (P/S) or the data registers. Rev 1.0
module bcrypt_core_din (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  din,
   input  logic [1:0]  ctrl,
   input  logic        core_busy,
   output logic        wr_en,
   output logic        wr_sel,
   output logic [10:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        init_done,
   output logic        data_done,
   output logic        rx_busy,
   output logic [2:0]  error
);

   localparam logic [1:0]  CTRL_INIT_START = 2'd1;
   localparam logic [1:0]  CTRL_DATA_START = 2'd2;
   localparam logic [1:0]  CTRL_END        = 2'd3;
   localparam logic [10:0] INIT_WORDS      = 11'd1054;
   localparam logic [10:0] DATA_WORDS      = 11'd31;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_INIT = 3'd1,
      S_RX_DATA = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [10:0] word_cnt_q, word_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic        wr_en_q, wr_en_d;
   logic        wr_sel_q, wr_sel_d;
   logic [10:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        init_done_q, init_done_d;
   logic        data_done_q, data_done_d;
   logic        rx_busy_q, rx_busy_d;
   logic [2:0]  error_q, error_d;
   logic [10:0] frame_len;
   logic [31:0] word_full;

   always_comb begin
      frame_len   = (state_q == S_RX_INIT) ? INIT_WORDS : DATA_WORDS;
      // The three earlier bytes sit in shift_q; the current byte completes the word.
      word_full   = {din, shift_q};
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      shift_d     = shift_q;
      wr_en_d     = 1'b0;
      wr_sel_d    = wr_sel_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      init_done_d = 1'b0;
      data_done_d = 1'b0;
      error_d     = error_q;

      case (state_q)
         // DONE decodes START like IDLE so back-to-back frames are never dropped.
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (ctrl == CTRL_INIT_START) begin
               state_d    = S_RX_INIT;
               wr_sel_d   = 1'b0;
               byte_cnt_d = 2'd0;
               word_cnt_d = 11'd0;
            end else if (ctrl == CTRL_DATA_START) begin
               if (core_busy) begin
                  error_d[2] = 1'b1;
                  state_d    = S_ERROR;
               end else begin
                  state_d    = S_RX_DATA;
                  wr_sel_d   = 1'b1;
                  byte_cnt_d = 2'd0;
                  word_cnt_d = 11'd0;
               end
            end
         end
         S_RX_INIT, S_RX_DATA: begin
            if (ctrl == CTRL_INIT_START || ctrl == CTRL_DATA_START) begin
               error_d[2] = 1'b1;
               state_d    = S_ERROR;
            end else begin
               shift_d    = word_full[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (word_cnt_q >= frame_len) begin
                     error_d[1] = 1'b1;
                     state_d    = S_ERROR;
                  end else begin
                     wr_en_d    = 1'b1;
                     wr_addr_d  = word_cnt_q;
                     wr_data_d  = word_full;
                     word_cnt_d = word_cnt_q + 11'd1;
                     if (ctrl == CTRL_END) begin
                        if (word_cnt_q == frame_len - 11'd1) begin
                           state_d     = S_DONE;
                           init_done_d = (state_q == S_RX_INIT);
                           data_done_d = (state_q == S_RX_DATA);
                        end else begin
                           error_d[1] = 1'b1;
                           state_d    = S_ERROR;
                        end
                     end
                  end
               end else if (ctrl == CTRL_END) begin
                  error_d[0] = 1'b1;
                  state_d    = S_ERROR;
               end
            end
         end
         default: state_d = S_ERROR;
      endcase

      rx_busy_d = (state_d == S_RX_INIT) || (state_d == S_RX_DATA) || (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= 2'd0;
         word_cnt_q  <= 11'd0;
         shift_q     <= 24'd0;
         wr_en_q     <= 1'b0;
         wr_sel_q    <= 1'b0;
         wr_addr_q   <= 11'd0;
         wr_data_q   <= 32'd0;
         init_done_q <= 1'b0;
         data_done_q <= 1'b0;
         rx_busy_q   <= 1'b0;
         error_q     <= 3'd0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         shift_q     <= shift_d;
         wr_en_q     <= wr_en_d;
         wr_sel_q    <= wr_sel_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         init_done_q <= init_done_d;
         data_done_q <= data_done_d;
         rx_busy_q   <= rx_busy_d;
         error_q     <= error_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_sel    = wr_sel_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign init_done = init_done_q;
   assign data_done = data_done_q;
   assign rx_busy   = rx_busy_q;
   assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bcrypt_core_din.sv
`default_nettype none
// tb_bcrypt_core_din -- frame-level bench for bcrypt_core_din against a word-list model.
module tb_bcrypt_core_din;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  din = 8'd0;
   logic [1:0]  ctrl = 2'd0;
   logic        core_busy = 1'b0;
   logic        wr_en, wr_sel, init_done, data_done, rx_busy;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  error;

   bcrypt_core_din dut (
      .CLK(CLK), .reset(reset), .din(din), .ctrl(ctrl), .core_busy(core_busy),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_done(init_done), .data_done(data_done), .rx_busy(rx_busy), .error(error)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        sel;
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      bit         is_init;
      bit         busy;
      int         nbytes;
      bit         rnd;
      bit         toggle;
      logic [2:0] exp_err;
      int         exp_writes;
      int         exp_done;
   } vec_t;

   wr_t        got_q[$];
   wr_t        exp_q[$];
   logic [7:0] fb[$];
   int         got_init_done, got_data_done, got_nocoinc;
   int         exp_init_done, exp_data_done;
   logic [2:0] exp_err;
   bit         model_dead;
   logic       busy_after_start;
   int         checks = 0;
   int         passed = 0;
   vec_t       vecs[11];

   always @(negedge CLK) begin
      if (wr_en) got_q.push_back({wr_sel, wr_addr, wr_data});
      if (init_done) got_init_done++;
      if (data_done) got_data_done++;
      if ((init_done || data_done) && !wr_en) got_nocoinc++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   // Reference: a frame is a list of bytes; every full group of four becomes a
   // little-endian word at consecutive addresses until the frame length is exceeded.
   function automatic void model_frame(input bit is_init, input bit busy);
      int len;
      int n;
      int nw;
      len = is_init ? 1054 : 31;
      n   = fb.size();
      nw  = n / 4;
      if (model_dead) return;
      if (!is_init && busy) begin
         exp_err[2] = 1'b1;
         model_dead = 1'b1;
         return;
      end
      for (int w = 0; w < nw; w++) begin
         if (w >= len) begin
            exp_err[1] = 1'b1;
            model_dead = 1'b1;
            return;
         end
         exp_q.push_back({~is_init, 11'(w), fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]});
      end
      if (n % 4 != 0) begin
         exp_err[0] = 1'b1;
         model_dead = 1'b1;
      end else if (nw != len) begin
         exp_err[1] = 1'b1;
         model_dead = 1'b1;
      end else if (is_init) exp_init_done++;
      else exp_data_done++;
   endfunction

   task automatic drive(input logic [1:0] c, input logic [7:0] d);
      ctrl = c;
      din  = d;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'd0, 8'd0);
   endtask

   task automatic fill(input int n, input bit rnd);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
   endtask

   task automatic send_frame(input bit is_init, input bit busy, input bit toggle);
      model_frame(is_init, busy);
      core_busy = busy;
      drive(is_init ? 2'd1 : 2'd2, 8'($urandom));
      busy_after_start = rx_busy;
      for (int i = 0; i < fb.size(); i++) begin
         if (toggle) core_busy = 1'($urandom);
         drive((i == fb.size() - 1) ? 2'd3 : 2'd0, fb[i]);
      end
      core_busy = 1'b0;
      ctrl      = 2'd0;
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      got_init_done = 0;
      got_data_done = 0;
      got_nocoinc   = 0;
      exp_init_done = 0;
      exp_data_done = 0;
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      ctrl      = 2'd0;
      din       = 8'd0;
      core_busy = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_outputs", {13'd0, wr_en, wr_sel, wr_addr, wr_data, init_done, data_done,
                            rx_busy, error}, 64'd0);
      reset = 1'b0;
      clear_obs();
      exp_err    = 3'd0;
      model_dead = 1'b0;
   endtask

   task automatic check_frame(input string name);
      int n;
      chk({name, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({name, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
      chk({name, "_error"}, 64'(error), 64'(exp_err));
      chk({name, "_init_done"}, 64'(got_init_done), 64'(exp_init_done));
      chk({name, "_data_done"}, 64'(got_data_done), 64'(exp_data_done));
      chk({name, "_done_with_wr"}, 64'(got_nocoinc), 64'd0);
      clear_obs();
   endtask

   initial begin
      //          init  busy bytes  rnd  tog  err     writes done
      vecs[0]  = '{1'b0, 1'b0, 124,  1'b0, 1'b0, 3'b000, 31,   1};
      vecs[1]  = '{1'b1, 1'b0, 4216, 1'b1, 1'b1, 3'b000, 1054, 1};
      vecs[2]  = '{1'b0, 1'b0, 123,  1'b0, 1'b0, 3'b001, 30,   0};
      vecs[3]  = '{1'b0, 1'b1, 124,  1'b1, 1'b0, 3'b100, 0,    0};
      vecs[4]  = '{1'b0, 1'b0, 128,  1'b0, 1'b0, 3'b010, 31,   0};
      vecs[5]  = '{1'b0, 1'b0, 120,  1'b1, 1'b1, 3'b010, 30,   0};
      vecs[6]  = '{1'b0, 1'b0, 124,  1'b1, 1'b1, 3'b000, 31,   1};
      vecs[7]  = '{1'b1, 1'b0, 4212, 1'b1, 1'b0, 3'b010, 1053, 0};
      vecs[8]  = '{1'b0, 1'b0, 1,    1'b1, 1'b0, 3'b001, 0,    0};
      vecs[9]  = '{1'b0, 1'b0, 125,  1'b0, 1'b0, 3'b001, 31,   0};
      vecs[10] = '{1'b1, 1'b0, 4220, 1'b1, 1'b0, 3'b010, 1054, 0};

      for (int v = 0; v < 11; v++) begin
         reset_dut();
         fill(vecs[v].nbytes, vecs[v].rnd);
         send_frame(vecs[v].is_init, vecs[v].busy, vecs[v].toggle);
         idle(3);
         chk("tbl_writes", 64'(got_q.size()), 64'(vecs[v].exp_writes));
         chk("tbl_error", 64'(error), 64'(vecs[v].exp_err));
         chk("tbl_done", 64'(got_init_done + got_data_done), 64'(vecs[v].exp_done));
         check_frame("tbl");
      end

      // Sequential data frame: last word and rx_busy while receiving.
      reset_dut();
      fill(124, 1'b0);
      send_frame(1'b0, 1'b0, 1'b0);
      chk("data_rx_busy", 64'(busy_after_start), 64'd1);
      idle(3);
      chk("data_last_word", (got_q.size() == 31) ? 64'(got_q[30]) : 64'hdead,
          64'({1'b1, 11'd30, 32'h7B7A7978}));
      check_frame("data_seq");

      // Init frame led by the first P-array word.
      reset_dut();
      fill(4216, 1'b1);
      fb[0] = 8'h88; fb[1] = 8'h6A; fb[2] = 8'h3F; fb[3] = 8'h24;
      send_frame(1'b1, 1'b0, 1'b0);
      idle(3);
      chk("init_first_word", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hdead,
          64'({1'b0, 11'd0, 32'h243F6A88}));
      check_frame("init_p0");

      // DATA_START while the core is busy locks the receiver until reset.
      reset_dut();
      fill(124, 1'b1);
      send_frame(1'b0, 1'b1, 1'b0);
      idle(2);
      fill(124, 1'b1);
      send_frame(1'b0, 1'b0, 1'b0);
      fill(4216, 1'b1);
      send_frame(1'b1, 1'b0, 1'b0);
      idle(3);
      chk("locked_rx_busy", 64'(rx_busy), 64'd0);
      check_frame("locked");

      // Reset in the middle of an init frame, then a clean data frame.
      reset_dut();
      drive(2'd1, 8'd0);
      for (int i = 0; i < 50; i++) drive(2'd0, 8'($urandom));
      reset_dut();
      fill(124, 1'b1);
      send_frame(1'b0, 1'b0, 1'b1);
      idle(3);
      check_frame("abort_init");

      // Back-to-back: START in the DONE cycle, then START after a one-cycle gap.
      reset_dut();
      fill(124, 1'b1);
      send_frame(1'b0, 1'b0, 1'b0);
      fill(124, 1'b1);
      send_frame(1'b0, 1'b0, 1'b0);
      idle(1);
      fill(124, 1'b1);
      send_frame(1'b0, 1'b0, 1'b0);
      idle(3);
      chk("b2b_done_count", 64'(got_data_done), 64'd3);
      check_frame("b2b");

      // A second START in the middle of a data frame.
      reset_dut();
      fill(10, 1'b1);
      drive(2'd2, 8'd0);
      for (int i = 0; i < 10; i++) drive(2'd0, fb[i]);
      drive(2'd1, 8'd0);
      idle(3);
      exp_q.push_back({1'b1, 11'd0, fb[3], fb[2], fb[1], fb[0]});
      exp_q.push_back({1'b1, 11'd1, fb[7], fb[6], fb[5], fb[4]});
      exp_err = 3'b100;
      check_frame("start_mid_frame");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
